// File: rtl/seg7_pkg.sv
// Shared BCD digit width, 7-segment code table and decode helper for the
// six-digit timer.
package seg7_pkg;

    localparam int BCD_W = 4;
    localparam int SEG_W = 7;
    localparam int N_DIGITS = 6;

    typedef logic [BCD_W-1:0] bcd_t;
    typedef logic [SEG_W-1:0] seg_t;

    localparam bcd_t BCD_MAX   = 4'd9;
    localparam seg_t SEG_BLANK = 7'h7F;

    // Active-low segments, bit0 = a ... bit6 = g. Codes 10..15 cannot occur in
    // a healthy counter, so they show blank rather than a misleading glyph.
    function automatic seg_t seg7_decode(input bcd_t d);
        seg_t seg;
        case (d)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_timer_core_if.sv
// Bundle of the timer's control and display signals. The master side
// controls run and watches the display; the slave side is the timer itself.
interface seg7_timer_core_if;
    import seg7_pkg::*;

    logic                       run;
    logic [N_DIGITS*BCD_W-1:0]  bcd;
    seg_t                       digit0;
    seg_t                       digit1;
    seg_t                       digit2;
    seg_t                       digit3;
    seg_t                       digit4;
    seg_t                       digit5;
    logic                       tick;
    logic                       carry_out;

    modport master (
        output run,
        input  bcd, digit0, digit1, digit2, digit3, digit4, digit5,
        input  tick, carry_out
    );

    modport slave (
        input  run,
        output bcd, digit0, digit1, digit2, digit3, digit4, digit5,
        output tick, carry_out
    );

endinterface

// File: rtl/seg7_timer_core_clock_div.sv
// Free-running clock-enable generator: one-cycle tick every DIV clocks,
// DIV = CLK_IN_HZ / CLK_OUT_HZ (must be at least 2).
module clock_div #(
    parameter int CLK_IN_HZ  = 50000000,
    parameter int CLK_OUT_HZ = 200000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int DIV   = CLK_IN_HZ / CLK_OUT_HZ;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == LAST);

    // Count 0..DIV-1 and wrap; reset restarts the period so the first tick
    // lands DIV cycles after release.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = w_last;

endmodule

// File: rtl/seg7_timer_core_seg7_counter.sv
// One decimal digit of the timer: 0..9 counter with combinational ripple
// carry and a 7-segment decode of the registered count.
module seg7_counter
    import seg7_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en_in,
    output bcd_t count,
    output seg_t seg7_out,
    output logic carry_out
);
    bcd_t r_count;
    bcd_t w_next;
    logic w_at_max;

    // Next count: advance when enabled, wrapping 9 -> 0.
    always_comb begin
        w_at_max = (r_count == BCD_MAX);
        w_next   = r_count;
        if (en_in) begin
            w_next = w_at_max ? '0 : r_count + bcd_t'(1);
        end
    end

    // Count register; reset wins over any enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    // Carry is combinational so the next digit moves on the same edge;
    // reset kills it so a carry pending at reset cannot leak through.
    assign carry_out = en_in & w_at_max & ~rst;
    assign count     = r_count;
    assign seg7_out  = seg7_decode(r_count);

endmodule

// File: rtl/seg7_timer_core.sv
// Six-digit BCD timer: a clock divider enables digit 0, and the digits ripple
// their carries combinationally so the whole count moves on one edge.
module seg7_timer_core
    import seg7_pkg::*;
#(
    parameter int CLK_IN_HZ  = 50000000,
    parameter int CLK_OUT_HZ = 200000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    output logic [N_DIGITS*BCD_W-1:0]  bcd,
    output seg_t                       digit0,
    output seg_t                       digit1,
    output seg_t                       digit2,
    output seg_t                       digit3,
    output seg_t                       digit4,
    output seg_t                       digit5,
    output logic                       tick,
    output logic                       carry_out
);
    logic w_tick;
    logic w_en [N_DIGITS+1];
    bcd_t w_count [N_DIGITS];
    seg_t w_seg [N_DIGITS];

    clock_div #(
        .CLK_IN_HZ  (CLK_IN_HZ),
        .CLK_OUT_HZ (CLK_OUT_HZ)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // The divider never stops; run only gates whether a tick reaches digit 0,
    // so a tick arriving with run low is simply dropped.
    assign w_en[0] = w_tick & run;

    seg7_counter u_dig0 (.clk(clk), .rst(rst), .en_in(w_en[0]), .count(w_count[0]),
                         .seg7_out(w_seg[0]), .carry_out(w_en[1]));
    seg7_counter u_dig1 (.clk(clk), .rst(rst), .en_in(w_en[1]), .count(w_count[1]),
                         .seg7_out(w_seg[1]), .carry_out(w_en[2]));
    seg7_counter u_dig2 (.clk(clk), .rst(rst), .en_in(w_en[2]), .count(w_count[2]),
                         .seg7_out(w_seg[2]), .carry_out(w_en[3]));
    seg7_counter u_dig3 (.clk(clk), .rst(rst), .en_in(w_en[3]), .count(w_count[3]),
                         .seg7_out(w_seg[3]), .carry_out(w_en[4]));
    seg7_counter u_dig4 (.clk(clk), .rst(rst), .en_in(w_en[4]), .count(w_count[4]),
                         .seg7_out(w_seg[4]), .carry_out(w_en[5]));
    seg7_counter u_dig5 (.clk(clk), .rst(rst), .en_in(w_en[5]), .count(w_count[5]),
                         .seg7_out(w_seg[5]), .carry_out(w_en[6]));

    assign bcd = {w_count[5], w_count[4], w_count[3], w_count[2], w_count[1], w_count[0]};

    assign digit0 = w_seg[0];
    assign digit1 = w_seg[1];
    assign digit2 = w_seg[2];
    assign digit3 = w_seg[3];
    assign digit4 = w_seg[4];
    assign digit5 = w_seg[5];

    assign tick      = w_tick;
    // Enable of a virtual seventh digit: high only on the 999999 -> 000000 edge.
    assign carry_out = w_en[N_DIGITS];

endmodule

// File: tb/tb_seg7_timer_core.sv
// Directed bench for seg7_timer_core with DIV = 10 (CLK_IN_HZ=10, CLK_OUT_HZ=1).
// Inputs change and outputs are sampled on the falling edge.
module tb_seg7_timer_core;
    import seg7_pkg::*;

    localparam int DIV = 10;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;
    int   nt;

    seg7_timer_core_if u_if ();

    seg7_timer_core #(
        .CLK_IN_HZ  (10),
        .CLK_OUT_HZ (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (u_if.run),
        .bcd       (u_if.bcd),
        .digit0    (u_if.digit0),
        .digit1    (u_if.digit1),
        .digit2    (u_if.digit2),
        .digit3    (u_if.digit3),
        .digit4    (u_if.digit4),
        .digit5    (u_if.digit5),
        .tick      (u_if.tick),
        .carry_out (u_if.carry_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance until a tick cycle is being observed (bounded).
    task automatic wait_tick();
        int k = 0;
        while (u_if.tick !== 1'b1 && k < 2 * DIV) begin
            step();
            k++;
        end
        if (u_if.tick !== 1'b1) check("tick_timeout", {63'd0, u_if.tick}, 64'd1);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            wait_tick();
            step();
        end
    endtask

    function automatic logic [63:0] all_digits();
        return {22'd0, u_if.digit5, u_if.digit4, u_if.digit3,
                u_if.digit2, u_if.digit1, u_if.digit0};
    endfunction

    initial begin
        rst      = 1'b1;
        u_if.run = 1'b1;
        @(negedge clk);

        // Reset held for three edges
        step(); step(); step();
        check("rst_bcd",   u_if.bcd, 24'h000000);
        check("rst_segs",  all_digits(), {22'd0, {6{7'h40}}});
        check("rst_tick",  u_if.tick, 1'b0);
        check("rst_carry", u_if.carry_out, 1'b0);

        // Divider: first tick in the 10th cycle after release
        rst = 1'b0;
        for (int c = 1; c <= DIV; c++) begin
            check($sformatf("div_cyc%0d", c), u_if.tick, (c == DIV) ? 1'b1 : 1'b0);
            if (c == DIV) check("div_hold_bcd", u_if.bcd, 24'h000000);
            step();
        end
        check("first_inc", u_if.bcd, 24'h000001);
        check("first_seg", u_if.digit0, 7'h79);

        // Periodic: 30 cycles hold exactly 3 ticks
        nt = 0;
        for (int i = 0; i < 3 * DIV; i++) begin
            if (u_if.tick === 1'b1) nt++;
            step();
        end
        check("div_period", nt, 3);
        check("bcd_4", u_if.bcd, 24'h000004);
        check("seg_4", u_if.digit0, 7'h19);

        // Single carry 9 -> 10
        run_ticks(5);
        check("bcd_9", u_if.bcd, 24'h000009);
        check("seg_9", u_if.digit0, 7'h10);
        wait_tick();
        check("pre_carry_bcd", u_if.bcd, 24'h000009);
        step();
        check("carry_bcd",  u_if.bcd, 24'h000010);
        check("carry_seg0", u_if.digit0, 7'h40);
        check("carry_seg1", u_if.digit1, 7'h79);

        // Pause: drop run on a tick cycle, tick must be discarded
        wait_tick();
        u_if.run = 1'b0;
        step();
        check("pause_drop", u_if.bcd, 24'h000010);
        nt = 0;
        for (int i = 0; i < 50 * DIV; i++) begin
            if (u_if.tick === 1'b1) nt++;
            step();
        end
        check("pause_ticks", nt, 50);
        check("pause_bcd",   u_if.bcd, 24'h000010);
        u_if.run = 1'b1;
        wait_tick();
        step();
        check("resume_bcd", u_if.bcd, 24'h000011);

        // Count up to 000459, then reset on a tick that carries out of digit 0
        run_ticks(448);
        check("bcd_459",  u_if.bcd, 24'h000459);
        check("segs_459", {u_if.digit2, u_if.digit1, u_if.digit0}, {7'h19, 7'h12, 7'h10});
        wait_tick();
        rst = 1'b1;
        step();
        check("midrst_bcd",   u_if.bcd, 24'h000000);
        check("midrst_carry", u_if.carry_out, 1'b0);
        check("midrst_tick",  u_if.tick, 1'b0);
        check("midrst_segs",  all_digits(), {22'd0, {6{7'h40}}});
        rst = 1'b0;

        // Unreachable code shows blank
        force dut.u_dig3.r_count = 4'd12;
        #1;
        check("blank_seg", u_if.digit3, 7'h7F);

        // Preload 999999 and wrap
        force dut.u_dig0.r_count = 4'd9;
        force dut.u_dig1.r_count = 4'd9;
        force dut.u_dig2.r_count = 4'd9;
        force dut.u_dig3.r_count = 4'd9;
        force dut.u_dig4.r_count = 4'd9;
        force dut.u_dig5.r_count = 4'd9;
        step();
        release dut.u_dig0.r_count;
        release dut.u_dig1.r_count;
        release dut.u_dig2.r_count;
        release dut.u_dig3.r_count;
        release dut.u_dig4.r_count;
        release dut.u_dig5.r_count;
        #1;
        check("pre_wrap_bcd",   u_if.bcd, 24'h999999);
        check("pre_wrap_seg5",  u_if.digit5, 7'h10);
        check("pre_wrap_carry", u_if.carry_out, 1'b0);
        wait_tick();
        check("wrap_carry_hi", u_if.carry_out, 1'b1);
        check("wrap_hold_bcd", u_if.bcd, 24'h999999);
        step();
        check("wrap_bcd",      u_if.bcd, 24'h000000);
        check("wrap_carry_lo", u_if.carry_out, 1'b0);
        check("wrap_segs",     all_digits(), {22'd0, {6{7'h40}}});
        step();
        check("wrap_carry_one", u_if.carry_out, 1'b0);
        wait_tick();
        step();
        check("post_wrap_bcd", u_if.bcd, 24'h000001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
